irq_request_latch: RTL

//  Clocked, parametrised interrupt request register (IRR) for the 8259-style PIC.
//  - Synchronises NUM_IRQ asynchronous request lines.
//  - Applies a per-channel edge or level trigger mode.
//  - Clears channels on interrupt acknowledge.
//  - Feeds IRR to the priority resolver and the ISR logic.

---
 rtl/pic_pkg.sv | 14 +
 rtl/irq_sync.sv | 31 +++
 rtl/irq_request_latch.sv | 60 ++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and helpers for the 8259-style PIC request path (IRQ_FILTER_EN adds filter delay)
package pic_pkg;
  localparam int PIC_NUM_IRQ_DEFAULT = 8;
  localparam int PIC_SYNC_STAGES_DEFAULT = 2;
  localparam logic TRIG_EDGE = 1'b0;
  localparam logic TRIG_LEVEL = 1'b1;
  function automatic int sync_latency(input int stages);
`ifdef IRQ_FILTER_EN
    return stages + 1;
`else
    return stages;
`endif
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: one-bit request synchroniser; IRQ_FILTER_EN adds a two-sample glitch filter
module irq_sync
  import pic_pkg::*;
#(
  parameter int STAGES = PIC_SYNC_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic s
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
`ifdef IRQ_FILTER_EN
  logic last, held;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      last <= 1'b0;
      held <= 1'b0;
    end else begin
      last <= chain[STAGES-1];
      held <= s;
    end
  // output moves only once two consecutive synchronised samples agree
  assign s = (chain[STAGES-1] == last) ? last : held;
`else
  assign s = chain[STAGES-1];
`endif
endmodule

// File: rtl/irq_request_latch.sv
// irq_request_latch: 8259-style interrupt request register with per-channel edge/level trigger
// Build option IRQ_FILTER_EN enables the glitch filter inside irq_sync.
module irq_request_latch
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = PIC_NUM_IRQ_DEFAULT,
  parameter int SYNC_STAGES = PIC_SYNC_STAGES_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] requests,
  input  logic [NUM_IRQ-1:0] LTIM,
  input  logic               init_clear,
  input  logic               ack,
  input  logic [NUM_IRQ-1:0] chosen,
  output logic [NUM_IRQ-1:0] IRR,
  output logic               irr_any
);
  localparam int WARM = sync_latency(SYNC_STAGES);
  localparam int CW = $clog2(WARM + 1);
  logic [NUM_IRQ-1:0] s, prev, irr_nxt, prev_nxt;
  logic [CW-1:0] cnt;
  logic warm;
  genvar i;
  generate
    for (i = 0; i < NUM_IRQ; i++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .d    (requests[i]),
        .s    (s[i])
      );
    end
  endgenerate
  // prev stays all-ones until the chains have flushed, so lines high at release are not edges
  assign warm = cnt != CW'(WARM);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else if (warm) cnt <= cnt + 1'b1;
  always_comb begin
    irr_nxt = IRR;
    for (int k = 0; k < NUM_IRQ; k++)
      irr_nxt[k] = init_clear ? 1'b0 :
                   (ack && chosen[k]) ? 1'b0 :
                   (LTIM[k] == TRIG_LEVEL) ? s[k] :
                   (s[k] && !prev[k]) ? 1'b1 :
                   !s[k] ? 1'b0 : IRR[k];
    prev_nxt = (init_clear || warm) ? '1 : s;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      IRR <= '0;
      prev <= '1;
      irr_any <= 1'b0;
    end else begin
      IRR <= irr_nxt;
      prev <= prev_nxt;
      irr_any <= |IRR;
    end
endmodule
